// File: rtl/prog_seq_pkg.sv
// Shared types and defaults for the program-run sequencer.
package prog_seq_pkg;

   localparam int unsigned DEF_PC_W  = 10;
   localparam int unsigned DEF_CNT_W = 16;

   typedef enum logic [2:0] {
      StIdle,
      StCoreRst,
      StReq,
      StRun,
      StLog,
      StFinish,
      StFault
   } seq_state_e;

endpackage

// File: rtl/run_watchdog.sv
// RUN-cycle counter with synchronous clear and enable, plus a terminal-count flag.
module run_watchdog #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count_inc,
   output logic             timeout
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count_inc;
      end
   end

   // count holds the RUN cycles already completed, so count_inc is the current cycle number.
   assign count_inc = count + CNT_W'(1);
   assign timeout   = (count_inc == CNT_W'(TIMEOUT));

endmodule

// File: rtl/prog_run_sequencer.sv
// Steps the core through NUM_PROGS programs: reset, load PC, pulse req, time the run, log.
module prog_run_sequencer
   import prog_seq_pkg::*;
#(
   parameter int unsigned NUM_PROGS = 3,
   parameter int unsigned PC_W      = DEF_PC_W,
   parameter int unsigned CNT_W     = DEF_CNT_W,
   parameter int unsigned TIMEOUT   = 50000,
   parameter int unsigned RST_CYC   = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      go,
   input  logic                      abort,
   input  logic [NUM_PROGS*PC_W-1:0] start_pcs,
   input  logic                      core_done,
   output logic                      core_rst,
   output logic                      core_req,
   output logic [PC_W-1:0]           core_pc,
   output logic                      busy,
   output logic                      all_done,
   output logic                      fault,
   output logic                      res_valid,
   output logic [2:0]                res_idx,
   output logic [CNT_W-1:0]          res_cycles
);

   localparam int unsigned      RCW      = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [RCW-1:0]   RST_LAST = RCW'(RST_CYC - 1);
   localparam logic [2:0]       LAST_IDX = 3'(NUM_PROGS - 1);

   seq_state_e       state;
   logic [2:0]       idx;
   logic [RCW-1:0]   rst_cnt;
   logic [2:0]       pc_sel;
   logic [PC_W-1:0]  next_pc;
   logic [CNT_W-1:0] cyc_now;
   logic             timeout;

   run_watchdog #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk       (clk),
      .reset     (reset),
      .clear     (state == StReq),
      .enable    (state == StRun),
      .count_inc (cyc_now),
      .timeout   (timeout)
   );

   // PC for the program about to enter CORE_RST: the next one from LOG, else program 0.
   assign pc_sel  = (state == StLog) ? idx + 3'd1 : 3'd0;
   assign next_pc = start_pcs[32'(pc_sel) * PC_W +: PC_W];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= StIdle;
         idx        <= '0;
         rst_cnt    <= '0;
         core_rst   <= 1'b1;
         core_req   <= 1'b0;
         core_pc    <= '0;
         busy       <= 1'b0;
         all_done   <= 1'b0;
         fault      <= 1'b0;
         res_valid  <= 1'b0;
         res_idx    <= '0;
         res_cycles <= '0;
      end else begin
         core_req  <= 1'b0;
         res_valid <= 1'b0;
         if (abort) begin
            state    <= StIdle;
            core_rst <= 1'b1;
            busy     <= 1'b0;
            all_done <= 1'b0;
            fault    <= 1'b0;
         end else begin
            unique case (state)
               StIdle, StFinish: begin
                  if (go) begin
                     state    <= StCoreRst;
                     idx      <= '0;
                     rst_cnt  <= '0;
                     core_pc  <= next_pc;
                     core_rst <= 1'b1;
                     busy     <= 1'b1;
                     all_done <= 1'b0;
                  end
               end
               StCoreRst: begin
                  if (rst_cnt == RST_LAST) begin
                     state    <= StReq;
                     core_rst <= 1'b0;
                     core_req <= 1'b1;
                  end else begin
                     rst_cnt <= rst_cnt + RCW'(1);
                  end
               end
               StReq: begin
                  state <= StRun;
               end
               StRun: begin
                  // Done outranks a same-cycle timeout.
                  if (core_done) begin
                     state      <= StLog;
                     res_valid  <= 1'b1;
                     res_idx    <= idx;
                     res_cycles <= cyc_now;
                  end else if (timeout) begin
                     state    <= StFault;
                     fault    <= 1'b1;
                     core_rst <= 1'b1;
                     busy     <= 1'b0;
                  end
               end
               StLog: begin
                  if (idx == LAST_IDX) begin
                     state    <= StFinish;
                     all_done <= 1'b1;
                     core_rst <= 1'b1;
                     busy     <= 1'b0;
                  end else begin
                     state    <= StCoreRst;
                     idx      <= idx + 3'd1;
                     rst_cnt  <= '0;
                     core_pc  <= next_pc;
                     core_rst <= 1'b1;
                  end
               end
               StFault: begin
               end
               default: begin
                  state <= StIdle;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prog_run_sequencer.sv
// Randomized and directed checks of prog_run_sequencer against a cycle-arithmetic core model.
module tb_prog_run_sequencer;

   localparam int NP      = 3;
   localparam int PCW     = 10;
   localparam int CW      = 16;
   localparam int TMO     = 20;
   localparam int RSTC    = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              go;
   logic              abort;
   logic [NP*PCW-1:0] start_pcs;
   logic              core_done;
   logic              core_rst;
   logic              core_req;
   logic [PCW-1:0]    core_pc;
   logic              busy;
   logic              all_done;
   logic              fault;
   logic              res_valid;
   logic [2:0]        res_idx;
   logic [CW-1:0]     res_cycles;

   int n_cmp = 0;
   int n_err = 0;
   int pcs[NP];
   int ns[NP];

   prog_run_sequencer #(
      .NUM_PROGS (NP),
      .PC_W      (PCW),
      .CNT_W     (CW),
      .TIMEOUT   (TMO),
      .RST_CYC   (RSTC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .go         (go),
      .abort      (abort),
      .start_pcs  (start_pcs),
      .core_done  (core_done),
      .core_rst   (core_rst),
      .core_req   (core_req),
      .core_pc    (core_pc),
      .busy       (busy),
      .all_done   (all_done),
      .fault      (fault),
      .res_valid  (res_valid),
      .res_idx    (res_idx),
      .res_cycles (res_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_pcs();
      for (int i = 0; i < NP; i++) start_pcs[i*PCW +: PCW] = PCW'(pcs[i]);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rst"},    32'(core_rst), 1);
      check({tag, "_req"},    32'(core_req), 0);
      check({tag, "_pc"},     32'(core_pc), 0);
      check({tag, "_busy"},   32'(busy), 0);
      check({tag, "_done"},   32'(all_done), 0);
      check({tag, "_fault"},  32'(fault), 0);
      check({tag, "_valid"},  32'(res_valid), 0);
      check({tag, "_idx"},    32'(res_idx), 0);
      check({tag, "_cycles"}, 32'(res_cycles), 0);
   endtask

   // Core model: wait for req, then finish after done_at RUN cycles (0 = never finishes).
   task automatic run_prog(input int pi, input int done_at, input bit abort_done);
      int  hi;
      bit  seen;
      int  last;
      hi   = 0;
      seen = 0;
      for (int w = 0; w < 40 && !seen; w++) begin
         if (core_req) seen = 1;
         else begin
            hi = core_rst ? hi + 1 : 0;
            step();
         end
      end
      check("req_seen", 32'(seen), 1);
      if (!seen) return;
      check("rst_len", hi, RSTC);
      check("req_rst_low", 32'(core_rst), 0);
      check("req_pc", 32'(core_pc), pcs[pi]);
      check("req_busy", 32'(busy), 1);
      step();
      check("req_width", 32'(core_req), 0);
      last = (done_at == 0) ? TMO : done_at;
      for (int k = 1; k <= last; k++) begin
         go        = (k == done_at && abort_done) ? 1'b0 : 1'($urandom_range(0, 1));
         core_done = (k == done_at);
         abort     = abort_done && (k == done_at);
         step();
         core_done = 1'b0;
         abort     = 1'b0;
         go        = 1'b0;
         if (k < last) begin
            check("run_novalid", 32'(res_valid), 0);
            check("run_pc", 32'(core_pc), pcs[pi]);
         end
      end
      if (abort_done) begin
         check("abrt_busy", 32'(busy), 0);
         check("abrt_valid", 32'(res_valid), 0);
         check("abrt_rst", 32'(core_rst), 1);
      end else if (done_at == 0) begin
         check("flt_fault", 32'(fault), 1);
         check("flt_rst", 32'(core_rst), 1);
         check("flt_valid", 32'(res_valid), 0);
         check("flt_busy", 32'(busy), 0);
      end else begin
         check("log_valid", 32'(res_valid), 1);
         check("log_idx", 32'(res_idx), pi);
         check("log_cycles", 32'(res_cycles), done_at);
         check("log_fault", 32'(fault), 0);
      end
   endtask

   task automatic run_seq();
      load_pcs();
      go = 1'b1;
      step();
      go = 1'b0;
      check("seq_busy", 32'(busy), 1);
      check("seq_rst", 32'(core_rst), 1);
      for (int i = 0; i < NP; i++) run_prog(i, ns[i], 1'b0);
      step();
      check("fin_all_done", 32'(all_done), 1);
      check("fin_busy", 32'(busy), 0);
      check("fin_rst", 32'(core_rst), 1);
      check("fin_valid", 32'(res_valid), 0);
      check("fin_hold", 32'(res_cycles), ns[NP-1]);
   endtask

   initial begin
      reset     = 1'b0;
      go        = 1'b0;
      abort     = 1'b0;
      core_done = 1'b0;
      start_pcs = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("por");
      reset = 1'b1;
      step();
      check("idle_rst", 32'(core_rst), 1);
      check("idle_busy", 32'(busy), 0);

      // Directed three-program sequence.
      pcs = '{0, 'h100, 'h200};
      ns  = '{5, 7, 1};
      run_seq();

      // Restarts from FINISH with random PCs and run lengths, incl. done at the timeout cycle.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < NP; i++) begin
            pcs[i] = int'($urandom_range(0, (1 << PCW) - 1));
            ns[i]  = int'($urandom_range(1, TMO));
         end
         if (r == 0) ns[1] = TMO;
         run_seq();
      end

      // Watchdog fault, go ignored while faulted, then abort.
      go = 1'b1;
      step();
      go = 1'b0;
      run_prog(0, 0, 1'b0);
      go = 1'b1;
      step();
      go = 1'b0;
      check("flt_sticky", 32'(fault), 1);
      check("flt_sticky_busy", 32'(busy), 0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("ab_fault", 32'(fault), 0);
      check("ab_busy", 32'(busy), 0);
      check("ab_rst", 32'(core_rst), 1);
      check("ab_all_done", 32'(all_done), 0);

      // Abort on the same cycle as done.
      go = 1'b1;
      step();
      go = 1'b0;
      run_prog(0, 3, 1'b1);
      step();
      check("ab_done_novalid", 32'(res_valid), 0);
      check("ab_done_idle", 32'(busy), 0);

      // Asynchronous reset in the middle of RUN.
      ns = '{9, 2, 3};
      load_pcs();
      go = 1'b1;
      step();
      go = 1'b0;
      for (int w = 0; w < 20 && !core_req; w++) step();
      check("mid_req", 32'(core_req), 1);
      repeat (3) step();
      #2 reset = 1'b0;
      #1 check_reset_vals("mid");
      #3 reset = 1'b1;
      step();
      check("post_rst_idle_rst", 32'(core_rst), 1);
      check("post_rst_idle_busy", 32'(busy), 0);
      run_seq();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "bench timed out");
   end

endmodule

// File: doc/prog_run_sequencer.md
Name: prog_run_sequencer

Overview:
Sequences the processor core (top_level) through a fixed list of programs.
- For each program: holds the core in reset, loads the program's start PC, pulses req, then waits for done.
- Reports the cycle count per program and flags a watchdog fault if a program never finishes.
- Sits above top_level and replaces the hand-driven reset/req/done sequencing used in simulation.

Parameters:
NUM_PROGS, 3, number of programs run per sequence (1..8)
PC_W, 10, start-PC width
CNT_W, 16, cycle-counter width
TIMEOUT, 50000, watchdog limit in RUN cycles; must be < 2**CNT_W
RST_CYC, 2, cycles core_rst is held per program (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
go  input  1  start sequence; sampled in IDLE and FINISH only
abort  input  1  return to IDLE from any state
start_pcs  input  NUM_PROGS*PC_W  packed start PCs, program i at bits [i*PC_W +: PC_W]
core_done  input  1  core done flag
core_rst  output  1  active-high reset to core
core_req  output  1  one-cycle start pulse to core
core_pc  output  PC_W  start PC presented to core
busy  output  1  high in CORE_RST, REQ, RUN, LOG
all_done  output  1  high in FINISH
fault  output  1  high in FAULT
res_valid  output  1  one-cycle result strobe
res_idx  output  3  program index for the result
res_cycles  output  CNT_W  RUN-cycle count for the result

Behaviour:
- Reset (reset==0, async): state IDLE, core_rst=1, core_req=0, core_pc=0, busy=0, all_done=0, fault=0, res_valid=0, res_idx=0, res_cycles=0, idx=0, counters=0. All outputs are registered.
- IDLE: core_rst=1. On go=1 → CORE_RST; set idx=0, rst_cnt=0.
- CORE_RST: core_rst=1; core_pc=start_pcs[idx]. Stay RST_CYC cycles, then → REQ.
- REQ: core_rst=0, core_req=1 for exactly one cycle. → RUN; cyc=0.
- RUN:
  - Each cycle, cyc increments by 1.
  - If core_done=1, the count reported is cyc+1, so done seen in the first RUN cycle reports 1. → LOG.
  - Else if cyc+1==TIMEOUT → FAULT.
  - core_done is ignored outside RUN.
- LOG:
  - res_valid=1 for one cycle; res_idx=idx; res_cycles=latched count. res_idx/res_cycles hold until the next strobe.
  - If idx==NUM_PROGS-1 → FINISH; else idx++ and → CORE_RST.
- FINISH: all_done=1, core_rst=1. go=1 → CORE_RST with idx=0 (restart).
- FAULT: fault=1, core_rst=1, res_valid never asserted. Exits only via abort or reset.
- Timing: core_pc is stable from CORE_RST entry through RUN exit.
- Priority and boundary rules:
  - abort beats every transition, including done or timeout in the same cycle. abort → IDLE next cycle; clears busy/all_done/fault; core_rst=1.
  - core_done and the timeout condition in the same cycle: done wins, result is logged.
  - go while busy is ignored.
  - Counter cannot wrap (TIMEOUT < 2**CNT_W).
- Latency per program: RST_CYC + 1 (REQ) + N (RUN) + 1 (LOG) cycles.

Decomposition:
- Package prog_seq_pkg:
  - state enum: IDLE, CORE_RST, REQ, RUN, LOG, FINISH, FAULT
  - default PC_W and CNT_W constants
- One sub-module is natural: run_watchdog, a CNT_W counter with clear, enable, and terminal-count compare. It provides both the cycle count and the timeout flag.

Test Plan:
1. Reset mid-RUN (reset=0 async) → all outputs at reset values within the same cycle; after release, state is IDLE with core_rst=1.
2. NUM_PROGS=3; start_pcs={0x200,0x100,0x000}; model asserts done after 5, 7, 1 RUN cycles → res_valid strobes with (0,5), (1,7), (2,1); core_pc shows 0x000, 0x100, 0x200 in turn; all_done=1 after the third LOG.
3. TIMEOUT=20; core never asserts done → fault=1 after 20 RUN cycles, core_rst=1, no res_valid; then abort → IDLE, fault=0.
4. core_done on the same cycle as cyc+1==TIMEOUT → LOG with res_cycles=TIMEOUT, no fault.
5. go pulsed during RUN is ignored. abort on the same cycle as core_done → IDLE, no res_valid.
6. In FINISH, go=1 → sequence restarts at idx 0. core_req is exactly one cycle wide every time. core_rst is high for exactly RST_CYC cycles before each req.
